uart_line_capture: RTL and testbench
====================================

// Module: uart_line_capture
// PURPOSE
//  Consumes the accepted-character stream from the UART terminal handler and assembles one command line
//  into the shared BRAM at bram[BASE_ADDR..]. Applies line editing (backspace, delete, ignored controls).
//  On CR/LF it writes a terminator byte, then pulses line_done. It holds the line locked until the game
//  logic acknowledges it with line_ack. It is the producer side of the in_burst_done handshake.
// PARAMETERS
//  BASE_ADDR  8'd0    first BRAM byte of the line buffer
//  MAX_LEN    127     max stored chars; the terminator fits below 128, the output region starts at 128
//  TERM       8'hFF   terminator byte written after the last char
//  ADDR_W     8       BRAM address width
// PORTS
//  clk        in   1       system clock (12 MHz)
//  rst        in   1       asynchronous, active-high reset
//  ch_valid   in   1       ch_data valid this cycle
//  ch_data    in   8       received byte (already echoed by terminal handler)
//  ch_ready   out  1       capture accepts a byte; a byte transfers on ch_valid & ch_ready
//  bram_addr  out  ADDR_W  BRAM write address (registered)
//  bram_din   out  8       BRAM write data (registered)
//  bram_we    out  1       BRAM write strobe, 1-cycle pulse per write
//  line_done  out  1       1-cycle pulse: line complete in BRAM
//  line_len   out  8       stored char count, valid from line_done until line_ack
//  overflow   out  1       sticky: chars were dropped in the current/last line
//  line_ack   in   1       consumer finished with line; reopens capture
// BEHAVIOUR
//  Reset (async, immediate): state=S_COLLECT, wr_ptr=0, bram_addr=BASE_ADDR, bram_din=0, bram_we=0,
//   line_done=0, line_len=0, overflow=0, cr_seen=0. A partial line is discarded; no terminator is written.
//  ch_ready = (state==S_COLLECT) (combinational). Each of the following applies to a byte accepted at edge N.
//  - Printable 0x20..0x7E, wr_ptr<MAX_LEN: cycle N+1 has bram_we=1, addr=BASE_ADDR+wr_ptr, din=byte; wr_ptr++.
//  - Printable, wr_ptr==MAX_LEN: no write; overflow<=1.
//  - 0x08 or 0x7F: wr_ptr-- if wr_ptr>0, else no-op. No BRAM write; stale bytes are left in place.
//  - 0x0D or 0x0A: cycle N+1 has bram_we=1, addr=BASE_ADDR+wr_ptr, din=TERM; line_len<=wr_ptr;
//    state<=S_TERM. cr_seen<=(byte==0x0D).
//  - 0x0A accepted while cr_seen=1 (CRLF tail): dropped, no line is produced.
//  - Every accepted byte except the CR that sets cr_seen clears cr_seen.
//  - 0x1B and all other bytes: dropped silently.
//  S_TERM (1 cycle): bram_we<=0, line_done<=1, wr_ptr<=0, state<=S_LOCKED.
//   line_done is high at cycle N+2 for exactly one cycle.
//  S_LOCKED: ch_ready=0 (the upstream rx buffer holds bytes); line_len and overflow are held stable.
//   line_ack is sampled here only, including the cycle in which line_done is high.
//   On line_ack: state<=S_COLLECT, overflow<=0. ch_ready is 1 on the next cycle.
//  line_ack in S_COLLECT or S_TERM: ignored.
//  Empty line (CR with wr_ptr=0): TERM is written at BASE_ADDR, line_len=0, line_done still pulses.
//  A backspace after overflow does not clear overflow. Subsequent printable chars store again if room exists.
//  Latency: byte to write is 1 cycle; terminator to line_done is 1 cycle. Max 1 write per cycle.
//  Width rules: wr_ptr is 8 bits, never exceeds MAX_LEN, never underflows.
//   bram_addr = BASE_ADDR + wr_ptr, truncated to ADDR_W.
// STRUCTURE
//  Shared header uart_text_defs.vh: char codes CH_CR, CH_LF, CH_BS, CH_DEL, CH_ESC; TERM_BYTE; OUT_BASE=128;
//   state encodings S_COLLECT / S_TERM / S_LOCKED.
//  Single flat module with one FSM plus the wr_ptr and cr_seen registers. No sub-module is warranted.
// TESTING
//  1. Send "go",CR -> writes 0x67@0, 0x6F@1, 0xFF@2. line_done 1 cycle after the TERM write. line_len=2,
//     overflow=0, ch_ready=0 until line_ack.
//  2. Send "ab",0x08,"c",LF -> bram[0..2] = 'a','c',0xFF. line_len=2. No write on the backspace.
//  3. Send 130 x 'x',CR -> 127 writes (addr 0..126), 0xFF@127. line_len=127, overflow=1.
//     line_ack clears overflow.
//  4. Send CR, line_ack, LF, "q", CR -> first line_len=0 with 0xFF@0. The LF is dropped.
//     The second line is 'q',0xFF with line_len=1.
//  5. Assert line_ack in the same cycle as line_done -> ch_ready=1 next cycle. Asserting line_ack while
//     collecting does nothing.
//  6. Assert rst after "abc" -> bram_we=0 immediately, all outputs at reset values. "z",CR -> 'z'@0, 0xFF@1.

Source files
------------

// File: rtl/uart_line_capture_pkg.sv
// Shared character codes, terminator and state encodings for the UART command-line capture path.
// The byte classifier lives here so every consumer of the char stream agrees on the editing rules.
package uart_line_capture_pkg;

  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_LF     = 8'h0A;
  localparam logic [7:0] CH_BS     = 8'h08;
  localparam logic [7:0] CH_DEL    = 8'h7F;
  localparam logic [7:0] CH_ESC    = 8'h1B;
  localparam logic [7:0] TERM_BYTE = 8'hFF;
  localparam int unsigned OUT_BASE = 128;

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_TERM    = 2'd1,
    S_LOCKED  = 2'd2
  } cap_state_t;

  typedef enum logic [1:0] {
    CC_PRINT = 2'd0,
    CC_ERASE = 2'd1,
    CC_EOL   = 2'd2,
    CC_DROP  = 2'd3
  } char_class_t;

  function automatic char_class_t classify(input logic [7:0] c);
    if (c == CH_ESC) return CC_DROP;
    if (c >= 8'h20 && c <= 8'h7E) return CC_PRINT;
    if (c == CH_BS || c == CH_DEL) return CC_ERASE;
    if (c == CH_CR || c == CH_LF) return CC_EOL;
    return CC_DROP;
  endfunction

endpackage

// File: rtl/uart_line_capture.sv
// Assembles one edited command line into BRAM, terminates it, pulses line_done and
// holds the line locked (ch_ready low) until the consumer returns line_ack.
module uart_line_capture
  import uart_line_capture_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       MAX_LEN   = OUT_BASE - 1,
  parameter logic [7:0]        TERM      = TERM_BYTE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ch_valid,
  input  logic [7:0]        ch_data,
  output logic              ch_ready,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [7:0]        bram_din,
  output logic              bram_we,
  output logic              line_done,
  output logic [7:0]        line_len,
  output logic              overflow,
  input  logic              line_ack
);

  cap_state_t  state, state_nxt;
  logic [7:0]  wr_ptr;
  logic        cr_seen;
  logic        accept;
  logic        crlf_tail;
  logic        room;
  logic        eol_go;
  char_class_t cls;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [7:0] p);
    return BASE_ADDR + ADDR_W'(p);
  endfunction

  assign ch_ready  = (state == S_COLLECT);
  assign accept    = ch_valid && (state == S_COLLECT);
  assign cls       = classify(ch_data);
  // An LF right after the CR that closed the previous line is the tail of a CRLF pair.
  assign crlf_tail = (ch_data == CH_LF) && cr_seen;
  assign room      = (wr_ptr < 8'(MAX_LEN));
  assign eol_go    = accept && (cls == CC_EOL) && !crlf_tail;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_COLLECT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_COLLECT: if (eol_go) state_nxt = S_TERM;
      S_TERM:    state_nxt = S_LOCKED;
      S_LOCKED:  if (line_ack) state_nxt = S_COLLECT;
      default:   state_nxt = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= 8'd0;
      cr_seen   <= 1'b0;
      bram_addr <= BASE_ADDR;
      bram_din  <= 8'd0;
      bram_we   <= 1'b0;
      line_done <= 1'b0;
      line_len  <= 8'd0;
      overflow  <= 1'b0;
    end else begin
      bram_we   <= 1'b0;
      line_done <= 1'b0;
      case (state)
        S_COLLECT: begin
          if (accept) begin
            cr_seen <= 1'b0;
            case (cls)
              CC_PRINT: begin
                if (room) begin
                  bram_we   <= 1'b1;
                  bram_addr <= addr_of(wr_ptr);
                  bram_din  <= ch_data;
                  wr_ptr    <= wr_ptr + 8'd1;
                end else begin
                  overflow  <= 1'b1;
                end
              end
              // Erase only moves the pointer; the stale byte is overwritten or sits past the terminator.
              CC_ERASE: if (wr_ptr != 8'd0) wr_ptr <= wr_ptr - 8'd1;
              CC_EOL: begin
                if (!crlf_tail) begin
                  bram_we   <= 1'b1;
                  bram_addr <= addr_of(wr_ptr);
                  bram_din  <= TERM;
                  line_len  <= wr_ptr;
                  cr_seen   <= (ch_data == CH_CR);
                end
              end
              default: ;
            endcase
          end
        end
        S_TERM: begin
          line_done <= 1'b1;
          wr_ptr    <= 8'd0;
        end
        S_LOCKED: if (line_ack) overflow <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_line_capture.sv
// Randomized bench for uart_line_capture: a queue-based line-editing model predicts every
// BRAM write, the line_done/ready timing, line_len and overflow, plus directed scenarios.
module tb_uart_line_capture;

  localparam logic [7:0] TB_TERM = 8'hFF;
  localparam int         TB_MAX  = 127;
  localparam int P_COL = 0, P_T1 = 1, P_T2 = 2, P_LOCK = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ch_valid = 1'b0;
  logic [7:0] ch_data = 8'd0;
  logic       ch_ready;
  logic [7:0] bram_addr;
  logic [7:0] bram_din;
  logic       bram_we;
  logic       line_done;
  logic [7:0] line_len;
  logic       overflow;
  logic       line_ack;
  logic       ack_auto = 1'b0;
  logic       ack_spur = 1'b0;

  assign line_ack = ack_auto | ack_spur;

  uart_line_capture dut (
    .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready),
    .bram_addr(bram_addr), .bram_din(bram_din), .bram_we(bram_we), .line_done(line_done),
    .line_len(line_len), .overflow(overflow), .line_ack(line_ack)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [7:0] tb_mem [0:255];
  logic [7:0] m_buf[$];
  logic [7:0] exp_line[$];
  int         m_phase = P_COL;
  logic       m_ovf = 1'b0;
  logic       m_cr = 1'b0;
  logic [7:0] m_len = 8'd0;
  logic       e_we = 1'b0, e_done = 1'b0, e_ready = 1'b1, e_ovf = 1'b0;
  logic [7:0] e_addr = 8'd0, e_din = 8'd0, e_len = 8'd0;
  logic       acc_flag = 1'b0;
  logic [7:0] last_len = 8'd0;
  logic       last_ovf = 1'b0;
  bit         ack_fast = 1'b0;
  int         ack_cnt = 0;

  initial for (int i = 0; i < 256; i++) tb_mem[i] = 8'h00;

  task automatic model_accept(input logic [7:0] b);
    logic was_cr;
    was_cr = m_cr;
    m_cr = 1'b0;
    if (b >= 8'h20 && b <= 8'h7E) begin
      if (m_buf.size() < TB_MAX) begin
        e_we = 1'b1; e_addr = 8'(m_buf.size()); e_din = b;
        m_buf.push_back(b);
      end else begin
        m_ovf = 1'b1;
      end
    end else if (b == 8'h08 || b == 8'h7F) begin
      if (m_buf.size() > 0) void'(m_buf.pop_back());
    end else if (b == 8'h0D || b == 8'h0A) begin
      if (!(b == 8'h0A && was_cr)) begin
        e_we = 1'b1; e_addr = 8'(m_buf.size()); e_din = TB_TERM;
        m_len = 8'(m_buf.size());
        exp_line = m_buf;
        m_buf.delete();
        m_cr = (b == 8'h0D);
        m_phase = P_T1;
      end
    end
  endtask

  always @(negedge clk) begin
    acc_flag = 1'b0;
    if (rst) begin
      check_eq("rst_we", bram_we, 0);
      check_eq("rst_done", line_done, 0);
      check_eq("rst_ready", ch_ready, 1);
      check_eq("rst_len", line_len, 0);
      check_eq("rst_ovf", overflow, 0);
      m_buf.delete(); m_ovf = 1'b0; m_cr = 1'b0; m_len = 8'd0; m_phase = P_COL;
      e_we = 1'b0; e_done = 1'b0; e_ready = 1'b1; e_ovf = 1'b0; e_len = 8'd0;
    end else begin
      if (bram_we) tb_mem[bram_addr] = bram_din;
      check_eq("ready", ch_ready, e_ready);
      check_eq("we", bram_we, e_we);
      if (e_we && bram_we) begin
        check_eq("addr", bram_addr, e_addr);
        check_eq("din", bram_din, e_din);
      end
      check_eq("done", line_done, e_done);
      check_eq("ovf", overflow, e_ovf);
      check_eq("len", line_len, e_len);
      if (m_phase == P_T2) begin
        for (int i = 0; i < exp_line.size(); i++) check_eq("line_byte", tb_mem[i], exp_line[i]);
        check_eq("line_term", tb_mem[exp_line.size()], TB_TERM);
        last_len = line_len;
        last_ovf = overflow;
      end
      acc_flag = ch_valid & ch_ready;
      e_we = 1'b0;
      case (m_phase)
        P_COL:  if (acc_flag) model_accept(ch_data);
        P_T1:   m_phase = P_T2;
        default: begin
          if (line_ack) begin m_phase = P_COL; m_ovf = 1'b0; end
          else m_phase = P_LOCK;
        end
      endcase
      e_ready = (m_phase == P_COL);
      e_done  = (m_phase == P_T2);
      e_ovf   = m_ovf;
      e_len   = m_len;
    end
  end

  // Consumer: acknowledges each line after 0..3 cycles (0 = same cycle as line_done).
  initial begin
    forever begin
      @(posedge clk); #2;
      ack_auto = 1'b0;
      if (ack_cnt > 0) begin
        ack_cnt--;
        if (ack_cnt == 0) ack_auto = 1'b1;
      end else if (line_done) begin
        ack_cnt = ack_fast ? 0 : $urandom % 4;
        if (ack_cnt == 0) ack_auto = 1'b1;
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int n;
    ch_valid = 1'b1; ch_data = b; n = 0;
    do begin @(posedge clk); n++; end while (!acc_flag && n < 300);
    #2;
    ch_valid = 1'b0; ch_data = 8'($urandom);
    if (n >= 300) check_eq("accept_timeout", 0, 1);
    if ($urandom % 4 == 0) repeat ($urandom % 3 + 1) begin @(posedge clk); #2; end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin @(posedge clk); #2; n++; end while (!(m_phase == P_COL && ch_ready) && n < 50);
    if (n >= 50) check_eq("idle_timeout", 0, 1);
  endtask

  function automatic logic [7:0] rand_body_byte();
    int r;
    logic [7:0] v;
    r = $urandom % 100;
    if (r < 75)      v = 8'(8'h20 + $urandom % 95);
    else if (r < 85) v = ($urandom % 2) ? 8'h08 : 8'h7F;
    else if (r < 92) v = 8'h1B;
    else begin
      v = 8'($urandom % 32);
      if (v == 8'h0A || v == 8'h0D) v = 8'h01;
    end
    return v;
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // "go",CR
    send_str("go"); send(8'h0D);
    wait_idle();
    check_eq("t1_len", last_len, 2);
    check_eq("t1_ovf", last_ovf, 0);
    check_eq("t1_m0", tb_mem[0], 8'h67);
    check_eq("t1_m1", tb_mem[1], 8'h6F);
    check_eq("t1_m2", tb_mem[2], 8'hFF);

    // "ab",BS,"c",LF
    send_str("ab"); send(8'h08); send_str("c"); send(8'h0A);
    wait_idle();
    check_eq("t2_len", last_len, 2);
    check_eq("t2_m1", tb_mem[1], 8'h63);
    check_eq("t2_m2", tb_mem[2], 8'hFF);

    // 130 x 'x',CR
    for (int i = 0; i < 130; i++) send(8'h78);
    send(8'h0D);
    wait_idle();
    check_eq("t3_len", last_len, 127);
    check_eq("t3_ovf", last_ovf, 1);
    check_eq("t3_m126", tb_mem[126], 8'h78);
    check_eq("t3_m127", tb_mem[127], 8'hFF);
    check_eq("t3_ovf_clear", overflow, 0);

    // CR (empty line), LF dropped, "q",CR
    send(8'h0D);
    wait_idle();
    check_eq("t4_len0", last_len, 0);
    check_eq("t4_m0", tb_mem[0], 8'hFF);
    send(8'h0A); send_str("q"); send(8'h0D);
    wait_idle();
    check_eq("t4_len1", last_len, 1);
    check_eq("t4_q", tb_mem[0], 8'h71);
    check_eq("t4_term", tb_mem[1], 8'hFF);

    // Ack in the line_done cycle; stray ack while collecting
    ack_fast = 1'b1;
    ack_spur = 1'b1;
    send_str("hi");
    ack_spur = 1'b0;
    send(8'h0D);
    wait_idle();
    ack_fast = 1'b0;
    check_eq("t5_len", last_len, 2);

    // Reset mid-line
    send_str("abc");
    rst = 1'b1;
    #1;
    check_eq("t6_we", bram_we, 0);
    check_eq("t6_addr", bram_addr, 0);
    check_eq("t6_din", bram_din, 0);
    check_eq("t6_len", line_len, 0);
    check_eq("t6_ready", ch_ready, 1);
    @(posedge clk); #2 rst = 1'b0;
    send_str("z"); send(8'h0D);
    wait_idle();
    check_eq("t6_z", tb_mem[0], 8'h7A);
    check_eq("t6_term", tb_mem[1], 8'hFF);
    check_eq("t6_zlen", last_len, 1);

    // Randomized lines
    for (int l = 0; l < 40; l++) begin
      int n, t;
      n = ($urandom % 8 == 0) ? 115 + $urandom % 25 : $urandom % 15;
      for (int k = 0; k < n; k++) send(rand_body_byte());
      t = $urandom % 3;
      if (t == 0)      send(8'h0D);
      else if (t == 1) send(8'h0A);
      else begin send(8'h0D); send(8'h0A); end
    end
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
